// File: rtl/operand_fwd_unit.sv
// operand_fwd_unit: bypass-network operand select with a registered, backpressured output stage.
// Define OPERAND_FWD_STALL_CNT_EN to add the saturating stall_cnt output.
module operand_fwd_unit #(
  parameter int DATA_W = 32,
  parameter int NPORT  = 2,
  parameter int NSTAGE = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NPORT*5-1:0]       rd_addr,
  input  logic [NPORT*DATA_W-1:0]  rf_data,
  input  logic [NSTAGE-1:0]        st_we,
  input  logic [NSTAGE*5-1:0]      st_addr,
  input  logic [NSTAGE*DATA_W-1:0] st_data,
  input  logic [NSTAGE-1:0]        st_rdy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NPORT*DATA_W-1:0]  out_data,
  output logic [NPORT-1:0]         out_fwd,
`ifdef OPERAND_FWD_STALL_CNT_EN
  output logic [31:0]              stall_cnt,
`endif
  output logic                     stall
);
  logic [NPORT*DATA_W-1:0] sel_data;
  logic [NPORT-1:0]        sel_fwd;
  logic [NPORT-1:0]        port_haz;
  logic                    hazard;
  logic                    accept;
  // Oldest-to-youngest walk so the youngest match overwrites; its readiness alone decides the hazard.
  always_comb begin
    sel_data = '0;
    sel_fwd  = '0;
    port_haz = '0;
    for (int p = 0; p < NPORT; p++) begin
      sel_data[p*DATA_W +: DATA_W] = rf_data[p*DATA_W +: DATA_W];
      for (int s = NSTAGE - 1; s >= 0; s--) begin
        if (st_we[s] && st_addr[s*5 +: 5] == rd_addr[p*5 +: 5]) begin
          sel_data[p*DATA_W +: DATA_W] = st_data[s*DATA_W +: DATA_W];
          sel_fwd[p]  = 1'b1;
          port_haz[p] = !st_rdy[s];
        end
      end
      if (rd_addr[p*5 +: 5] == 5'd0) begin
        sel_data[p*DATA_W +: DATA_W] = '0;
        sel_fwd[p]  = 1'b0;
        port_haz[p] = 1'b0;
      end
    end
  end
  assign hazard   = |port_haz;
  assign stall    = in_valid & hazard;
  assign in_ready = !hazard & !flush & (!out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_fwd   <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (accept) begin
        out_data <= sel_data;
        out_fwd  <= sel_fwd;
      end
    end
  end
`ifdef OPERAND_FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stall_cnt <= '0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_operand_fwd_unit.sv
// tb_operand_fwd_unit: directed checks of operand_fwd_unit selection, hazard, handshake and reset.
module tb_operand_fwd_unit;
  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, out_valid, out_ready, stall;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data, out_data;
  logic [2:0]  st_we, st_rdy;
  logic [14:0] st_addr;
  logic [95:0] st_data;
  logic [1:0]  out_fwd;
  int          total = 0;
  int          passed = 0;
`ifdef OPERAND_FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  operand_fwd_unit dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rd_addr(rd_addr), .rf_data(rf_data), .st_we(st_we), .st_addr(st_addr), .st_data(st_data),
    .st_rdy(st_rdy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_fwd(out_fwd),
`ifdef OPERAND_FWD_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .stall(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rd_addr = '0; rf_data = '0; st_we = '0; st_addr = '0; st_data = '0; st_rdy = '0;
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_fwd", out_fwd, 2'b00);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    @(negedge clk) resetn = 1'b1;
    rd_addr = {5'd5, 5'd3}; rf_data = {32'h11, 32'h22}; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("rf_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("rf_out_valid", out_valid, 1'b1);
    chk("rf_out_data", out_data, {32'h11, 32'h22});
    chk("rf_out_fwd", out_fwd, 2'b00);
    rd_addr = {5'd5, 5'd7}; rf_data = {32'h11, 32'h99};
    st_we = 3'b111; st_addr = {5'd7, 5'd7, 5'd7}; st_data = {32'hC, 32'hB, 32'hA}; st_rdy = 3'b111;
    @(negedge clk);
    chk("young_out_valid", out_valid, 1'b1);
    chk("young_out_data", out_data, {32'h11, 32'hA});
    chk("young_out_fwd", out_fwd, 2'b01);
    st_we = 3'b011; st_rdy = 3'b110; st_data = {32'hC, 32'hB, 32'hAA};
    for (int i = 0; i < 3; i++) begin
      #1 chk("haz_stall", stall, 1'b1);
      chk("haz_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    chk("haz_drained", out_valid, 1'b0);
    in_valid = 1'b0;
    #1 chk("haz_no_valid_stall", stall, 1'b0);
    chk("haz_no_valid_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; st_rdy = 3'b111;
    #1 chk("haz_clear_in_ready", in_ready, 1'b1);
    chk("haz_clear_stall", stall, 1'b0);
    @(negedge clk);
    chk("haz_out_valid", out_valid, 1'b1);
    chk("haz_out_data", out_data, {32'h11, 32'hAA});
    chk("haz_out_fwd", out_fwd, 2'b01);
`ifdef OPERAND_FWD_STALL_CNT_EN
    chk("stall_cnt_3", stall_cnt, 32'd3);
`endif
    rd_addr = {5'd0, 5'd3}; rf_data = {32'h55, 32'h22};
    st_we = 3'b001; st_addr = {5'd7, 5'd7, 5'd0}; st_data = {32'hC, 32'hB, 32'hDEAD};
    @(negedge clk);
    chk("r0_out_data", out_data, {32'h0, 32'h22});
    chk("r0_out_fwd", out_fwd, 2'b00);
    rd_addr = {5'd9, 5'd3}; st_we = 3'b100; st_addr = {5'd9, 5'd7, 5'd0}; st_data = {32'h77, 32'hB, 32'hDEAD};
    @(negedge clk);
    chk("old_out_data", out_data, {32'h77, 32'h22});
    chk("old_out_fwd", out_fwd, 2'b10);
    out_ready = 1'b0; rd_addr = {5'd3, 5'd3}; st_we = 3'b111; st_addr = {5'd3, 5'd3, 5'd3};
    for (int i = 0; i < 4; i++) begin
      st_data = {$urandom, $urandom, $urandom};
      #1 chk("hold_in_ready", in_ready, 1'b0);
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_data", out_data, {32'h77, 32'h22});
      chk("hold_out_fwd", out_fwd, 2'b10);
    end
    flush = 1'b1; out_ready = 1'b1;
    #1 chk("flush_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_data", out_data, {32'h77, 32'h22});
    flush = 1'b0; st_we = 3'b000; rd_addr = {5'd5, 5'd3}; rf_data = {32'h11, 32'h22};
    @(negedge clk);
    chk("post_flush_valid", out_valid, 1'b1);
    chk("post_flush_data", out_data, {32'h11, 32'h22});
    out_ready = 1'b0;
    #2 resetn = 1'b0;
    #1 chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 64'h0);
    chk("arst_out_fwd", out_fwd, 2'b00);
    chk("arst_in_ready", in_ready, 1'b1);
`ifdef OPERAND_FWD_STALL_CNT_EN
    chk("arst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk) resetn = 1'b1; out_ready = 1'b1; rf_data = {32'h33, 32'h44};
    @(negedge clk);
    chk("rel_out_valid", out_valid, 1'b1);
    chk("rel_out_data", out_data, {32'h33, 32'h44});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
